// File: rtl/rng_arb_pkg.sv
// Shared types and defaults for the random-number arbiter and its round-robin picker.
package rng_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STEP   = 2'd1,
        SAMPLE = 2'd2,
        ACK    = 2'd3
    } arb_state_t;

    localparam int NUM_REQ_DEF = 4;
    localparam int STEPS_DEF   = 7;
    localparam int RND_W_DEF   = 7;

    // Step counter must hold the full STEPS_PER_DRAW load value.
    function automatic int cnt_width(input int steps);
        return $clog2(steps + 1);
    endfunction

endpackage

// File: rtl/rng_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr, wrapping to 0.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] grant,
    output logic             valid
);

    logic [IDX_W-1:0] cand [N];
    logic [N-1:0]     hit;

    // cand[gi] is the requester index gi positions after the pointer.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cand
            logic [IDX_W:0] sum;
            assign sum       = {1'b0, ptr} + (IDX_W+1)'(gi);
            assign cand[gi]  = (sum >= (IDX_W+1)'(N)) ? IDX_W'(sum - (IDX_W+1)'(N))
                                                       : sum[IDX_W-1:0];
            assign hit[gi]   = req[cand[gi]];
        end
    endgenerate

    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (hit[i]) begin
                grant = cand[i];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rng_arbiter.sv
// Round-robin sharing of one LFSR generator: each draw advances it a fixed number of steps.
module rng_arbiter
    import rng_arb_pkg::*;
#(
    parameter int NUM_REQ        = NUM_REQ_DEF,
    parameter int STEPS_PER_DRAW = STEPS_DEF,
    parameter int RND_W          = RND_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] rnd_req,
    output logic [NUM_REQ-1:0] rnd_ack,
    output logic [RND_W-1:0]   rnd_data,
    output logic               rng_trigger,
    input  logic [RND_W-1:0]   rng_value,
    output logic               busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = cnt_width(STEPS_PER_DRAW);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_STEP   = STEP;
    localparam logic [1:0] S_SAMPLE = SAMPLE;
    localparam logic [1:0] S_ACK    = ACK;

    logic [1:0]       state_reg,  state_next;
    logic [IDX_W-1:0] ptr_reg,    ptr_next;
    logic [IDX_W-1:0] winner_reg, winner_next;
    logic [CNT_W-1:0] cnt_reg,    cnt_next;
    logic [RND_W-1:0] data_reg,   data_next;

    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (rnd_req),
        .ptr   (ptr_reg),
        .grant (pick_idx),
        .valid (pick_valid)
    );

    always_comb begin
        state_next  = state_reg;
        ptr_next    = ptr_reg;
        winner_next = winner_reg;
        cnt_next    = cnt_reg;
        data_next   = data_reg;
        case (state_reg)
            S_IDLE: begin
                if (pick_valid) begin
                    winner_next = pick_idx;
                    cnt_next    = CNT_W'(STEPS_PER_DRAW);
                    state_next  = S_STEP;
                end
            end
            S_STEP: begin
                // One trigger per cycle here; leaving on count 1 yields exactly STEPS_PER_DRAW.
                cnt_next = cnt_reg - CNT_W'(1);
                if (cnt_reg <= CNT_W'(1)) begin
                    state_next = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                data_next  = rng_value;
                ptr_next   = (winner_reg == IDX_W'(NUM_REQ - 1)) ? '0 : winner_reg + IDX_W'(1);
                state_next = S_ACK;
            end
            S_ACK: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            ptr_reg    <= '0;
            winner_reg <= '0;
            cnt_reg    <= '0;
            data_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            ptr_reg    <= ptr_next;
            winner_reg <= winner_next;
            cnt_reg    <= cnt_next;
            data_reg   <= data_next;
        end
    end

    // Outputs decode from registers only, so reset silences them immediately.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ack
            assign rnd_ack[gi] = (state_reg == S_ACK) && (winner_reg == IDX_W'(gi));
        end
    endgenerate

    assign rng_trigger = (state_reg == S_STEP);
    assign busy        = (state_reg != S_IDLE);
    assign rnd_data    = data_reg;

endmodule

// File: tb/tb_rng_arbiter.sv
// Self-checking bench for rng_arbiter with a simple stepping generator model.
module tb_rng_arbiter;

    localparam int SEED = 42;
    localparam int GEN_STEP = 37;

    logic       clk;
    logic       rst_n;
    logic [3:0] rnd_req;
    logic [3:0] rnd_ack;
    logic [6:0] rnd_data;
    logic       rng_trigger;
    logic [6:0] rng_value;
    logic       busy;

    rng_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rnd_req     (rnd_req),
        .rnd_ack     (rnd_ack),
        .rnd_data    (rnd_data),
        .rng_trigger (rng_trigger),
        .rng_value   (rng_value),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Generator model: advances by a fixed step mod 100 on each trigger.
    logic [6:0] gen_reg;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)           gen_reg <= 7'(SEED);
        else if (rng_trigger) gen_reg <= 7'((int'(gen_reg) + GEN_STEP) % 100);
    end
    assign rng_value = gen_reg;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] ack;
        logic [6:0] data;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [3:0] req;
        logic [3:0] exp_ack;
    } vec_t;

    exp_t sb_q[$];
    int checks = 0;
    int failures = 0;
    int n_draw = 0;
    int trig_cnt = 0;
    logic [6:0] last_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [6:0] draw_value(input int n);
        return 7'((SEED + GEN_STEP * 7 * n) % 100);
    endfunction

    // Scoreboard monitor: pops one expectation per ack pulse.
    always @(negedge clk) begin
        if (!rst_n) begin
            trig_cnt = 0;
        end else begin
            if (rng_trigger) trig_cnt++;
            if (rnd_ack != 4'b0000) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_ack", 32'(rnd_ack), 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    $display("ack=%b data=%0d cycle=%0d triggers=%0d (exp ack=%b data=%0d cycle=%0d)",
                             rnd_ack, rnd_data, cyc, trig_cnt, e.ack, e.data, e.cyc);
                    check("ack_vec", 32'(rnd_ack), 32'(e.ack));
                    check("ack_cycle", 32'(cyc), 32'(e.cyc));
                    check("ack_data", 32'(rnd_data), 32'(e.data));
                    check("trig_per_draw", 32'(trig_cnt), 32'd7);
                    check("data_range", 32'(rnd_data <= 7'd99), 32'd1);
                end
                trig_cnt = 0;
            end
        end
    end

    task automatic wait_empty();
        int k = 0;
        while (sb_q.size() != 0 && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (sb_q.size() != 0) begin
            check("ack_timeout", 32'(sb_q.size()), 32'd0);
            sb_q.delete();
        end
    endtask

    task automatic push_exp(input logic [3:0] ack, input int c);
        exp_t e;
        n_draw++;
        e.ack  = ack;
        e.data = draw_value(n_draw);
        e.cyc  = c;
        sb_q.push_back(e);
        last_data = e.data;
    endtask

    task automatic do_draw(input logic [3:0] req, input logic [3:0] exp_ack);
        int c;
        @(posedge clk);
        #1;
        rnd_req = req;
        c = cyc;
        push_exp(exp_ack, c + 9);
        wait_empty();
        @(posedge clk);
        #1;
        rnd_req = 4'b0000;
    endtask

    vec_t vecs[10];

    initial begin
        int c;
        int quiet_trig;
        int quiet_busy;

        vecs[0] = '{4'b0010, 4'b0010};
        vecs[1] = '{4'b0101, 4'b0100};
        vecs[2] = '{4'b0101, 4'b0001};
        vecs[3] = '{4'b0101, 4'b0100};
        vecs[4] = '{4'b1000, 4'b1000};
        vecs[5] = '{4'b1001, 4'b0001};
        vecs[6] = '{4'b1111, 4'b0010};
        vecs[7] = '{4'b0011, 4'b0001};
        vecs[8] = '{4'b0100, 4'b0100};
        vecs[9] = '{4'b0001, 4'b0001};

        rst_n   = 1'b0;
        rnd_req = 4'b0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", 32'(rnd_ack), 32'd0);
        check("rst_data", 32'(rnd_data), 32'd0);
        check("rst_trigger", 32'(rng_trigger), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        // All requesters held: strict rotation 0,1,2,3,0 every 10 cycles.
        @(posedge clk);
        #1;
        rnd_req = 4'b1111;
        c = cyc;
        for (int k = 0; k < 5; k++) push_exp(4'(4'b0001 << (k % 4)), c + 9 + 10 * k);
        wait_empty();
        @(posedge clk);
        #1;
        rnd_req = 4'b0000;

        // Table-driven single draws, including pointer wrap with 0101.
        for (int i = 0; i < 10; i++) do_draw(vecs[i].req, vecs[i].exp_ack);

        // Request dropped in STEP: ack still issued, pointer still advances.
        @(posedge clk);
        #1;
        rnd_req = 4'b0010;
        c = cyc;
        push_exp(4'b0010, c + 9);
        repeat (3) @(posedge clk);
        #1;
        rnd_req = 4'b0000;
        wait_empty();
        do_draw(4'b0111, 4'b0100);

        // Quiet idle.
        quiet_trig = 0;
        quiet_busy = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rng_trigger) quiet_trig++;
            if (busy) quiet_busy++;
        end
        check("quiet_trigger", 32'(quiet_trig), 32'd0);
        check("quiet_busy", 32'(quiet_busy), 32'd0);
        check("quiet_data", 32'(rnd_data), 32'(last_data));

        // Reset with the step counter at 4.
        @(posedge clk);
        #1;
        rnd_req = 4'b0001;
        repeat (4) @(posedge clk);
        #1;
        rnd_req = 4'b0000;
        check("pre_rst_busy", 32'(busy), 32'd1);
        check("pre_rst_trigger", 32'(rng_trigger), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_trigger", 32'(rng_trigger), 32'd0);
        check("mid_rst_ack", 32'(rnd_ack), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_data", 32'(rnd_data), 32'd0);
        n_draw = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_draw(4'b0001, 4'b0001);

        repeat (5) @(negedge clk);
        check("final_queue_empty", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/rng_arbiter.md
Name: rng_arbiter

Overview:
- Shares the single 7-bit LFSR random-number generator (`rng`, output 0..99) among several game requesters, such as obstacle spawner, enemy AI and power-up placer.
- Grants one requester at a time using round-robin arbitration.
- Issues exactly STEPS_PER_DRAW trigger pulses to the generator so that successive draws are decorrelated.
- Returns the sampled value to the winner with a one-cycle acknowledge.
- Sits between the game-logic modules and the `rng` instance. It is the only driver of the generator's trigger.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- STEPS_PER_DRAW, 7, generator advance pulses per draw (1..15); 7 gives a full register refresh.
- RND_W, 7, random value width; matches the generator output.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rnd_req  in  NUM_REQ  per-requester draw request; level, held until the matching ack
- rnd_ack  out  NUM_REQ  one-hot, one-cycle pulse; rnd_data is valid in this cycle
- rnd_data  out  RND_W  last delivered value; held stable until the next ack
- rng_trigger  out  1  clock-enable pulse to the generator
- rng_value  in  RND_W  generator output (combinational from its register; reflects a trigger one cycle later)
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync-safe deassert) sets state=IDLE, rnd_ack=0, rnd_data=0, rng_trigger=0, priority pointer=0, winner=0, step counter=0.
- All outputs are registered or decoded directly from state/registers. There is no combinational path from rnd_req to any output.
- FSM states:
  - IDLE:
    - If rnd_req≠0, pick the winner: the first set bit searching upward from the pointer, wrapping at NUM_REQ-1→0.
    - Latch the winner, load counter=STEPS_PER_DRAW, go to STEP.
    - Otherwise stay in IDLE.
  - STEP:
    - rng_trigger=1 for every cycle in this state; counter decrements each cycle.
    - When the counter reaches 1, go to SAMPLE. Total trigger pulses per draw = STEPS_PER_DRAW exactly.
  - SAMPLE:
    - rng_trigger=0; rng_value now reflects the final advance.
    - rnd_data<=rng_value; pointer<=(winner+1) mod NUM_REQ; go to ACK.
  - ACK:
    - rnd_ack[winner]=1 for exactly one cycle, then IDLE.
    - A requester wanting no further draws deasserts rnd_req at the clock edge that ends the ACK cycle.
- Latency: a request seen in IDLE at cycle t produces triggers at t+1..t+S, SAMPLE at t+S+1, ack at t+S+2 (S=STEPS_PER_DRAW).
- Throughput: one draw per S+3 cycles.
- A request held continuously is re-arbitrated against others in the next IDLE. Round-robin guarantees at most NUM_REQ-1 intervening draws.
- Request dropped mid-draw: the draw still completes and the ack is still issued for the latched winner. The consumer ignores it; the pointer advances normally.
- New requests arriving during STEP/SAMPLE/ACK are only considered in the next IDLE.
- rnd_data changes only in SAMPLE; otherwise it holds its value.
- Reset asserted in any state immediately forces all reset values. No trigger or ack is emitted after reset asserts. A partially advanced generator is acceptable.
- Generator zero-lock recovery is internal to the generator; the arbiter does not inspect rng_value.

Decomposition:
- Package `rng_arb_pkg`:
  - state enum (IDLE, STEP, SAMPLE, ACK)
  - default constants NUM_REQ_DEF=4, STEPS_DEF=7, RND_W=7
  - counter width function clog2(STEPS_PER_DRAW+1)
- Sub-module `rr_pick`: combinational round-robin selector. Inputs: request vector and pointer. Outputs: grant index and any-valid flag. It is reused by other shared-resource controllers in the game.

Test Plan:
- Single request, S=7, requests at cycle 0:
  - rnd_req=4'b0010 → rng_trigger high cycles 1..7 (7 pulses), rnd_ack=4'b0010 at cycle 9, rnd_data = the rng_value present at cycle 8.
- All request after reset, held:
  - rnd_req=4'b1111 → acks in order 0,1,2,3,0, each spaced 10 cycles apart.
  - Triggers total exactly 7 per ack; rnd_data never exceeds 99.
- Pointer wrap:
  - After a grant to requester 2, rnd_req=4'b0101 → next grant is 0, then 2.
  - Requester 3 absent never blocks.
- Request dropped mid-draw:
  - rnd_req[1] deasserted in the STEP state → ack[1] still pulses at the expected cycle.
  - Next grant goes to requester 2 or higher.
- Reset mid-STEP (counter=4):
  - Assert rst_n=0 → rng_trigger, rnd_ack and busy drop to 0 in the same cycle; rnd_data=0.
  - After release with rnd_req=4'b0001, a fresh 7-pulse draw occurs.
- Idle quiet:
  - rnd_req=0 for 100 cycles → rng_trigger never asserted, busy=0, rnd_data unchanged.
